// File: rtl/parking_pkg.sv
// Shared types for the parking-lot counter: gate FSM states and a small popcount helper.
// Pure declarations; no latency or backpressure of its own.
package parking_pkg;

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} gate_state_e;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// One gate: synchronises the outer/inner beams and decodes complete enter/exit sequences.
// Pulse lands SYNC_STAGES+1 edges after the final 00 at the pins; no backpressure, sensors are free-running.
module parking_gate_fsm #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic outer,
  input  logic inner,
  output logic enter_pulse,
  output logic exit_pulse
);
  import parking_pkg::*;

  logic [SYNC_STAGES-1:0] outer_sync;
  logic [SYNC_STAGES-1:0] inner_sync;
  logic [1:0]             ab;
  gate_state_e            state;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      outer_sync <= '0;
      inner_sync <= '0;
    end else begin
      outer_sync <= {outer_sync[SYNC_STAGES-2:0], outer};
      inner_sync <= {inner_sync[SYNC_STAGES-2:0], inner};
    end
  end

  assign ab = {outer_sync[SYNC_STAGES-1], inner_sync[SYNC_STAGES-1]};

  // Exit states mirror the entry states with the two beams swapped.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
    end else begin
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      case (state)
        IDLE: case (ab)
          2'b10:   state <= EN1;
          2'b01:   state <= EX1;
          default: state <= IDLE;
        endcase
        EN1: case (ab)
          2'b10:   state <= EN1;
          2'b11:   state <= EN2;
          default: state <= IDLE;
        endcase
        EN2: case (ab)
          2'b11:   state <= EN2;
          2'b01:   state <= EN3;
          2'b10:   state <= EN1;
          default: state <= IDLE;
        endcase
        EN3: case (ab)
          2'b01:   state <= EN3;
          2'b11:   state <= EN2;
          2'b00: begin
            state       <= IDLE;
            enter_pulse <= 1'b1;
          end
          default: state <= IDLE;
        endcase
        EX1: case (ab)
          2'b01:   state <= EX1;
          2'b11:   state <= EX2;
          default: state <= IDLE;
        endcase
        EX2: case (ab)
          2'b11:   state <= EX2;
          2'b10:   state <= EX3;
          2'b01:   state <= EX1;
          default: state <= IDLE;
        endcase
        EX3: case (ab)
          2'b10:   state <= EX3;
          2'b11:   state <= EX2;
          2'b00: begin
            state      <= IDLE;
            exit_pulse <= 1'b1;
          end
          default: state <= IDLE;
        endcase
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/parking_lot_counter.sv
// Multi-gate occupancy counter: per-gate decoders feed a saturating count with full/empty and sticky errors.
// Count follows a gate pulse by one edge; no backpressure, out-of-range events are clamped and flagged.
module parking_lot_counter #(
  parameter int NUM_GATES   = 2,
  parameter int CAPACITY    = 25,
  parameter int SYNC_STAGES = 2,
  localparam int CNT_W      = $clog2(CAPACITY + 1)
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] outer,
  input  logic [NUM_GATES-1:0] inner,
  input  logic                 clear_err,
  output logic [NUM_GATES-1:0] enter_pulse,
  output logic [NUM_GATES-1:0] exit_pulse,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf_err,
  output logic                 unf_err
);
  import parking_pkg::*;

  localparam int TW = CNT_W + 4;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    parking_gate_fsm #(.SYNC_STAGES(SYNC_STAGES)) u_gate (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .outer       (outer[g]),
      .inner       (inner[g]),
      .enter_pulse (enter_pulse[g]),
      .exit_pulse  (exit_pulse[g])
    );
  end

  logic [3:0]           n_enter;
  logic [3:0]           n_exit;
  logic signed [TW-1:0] next_t;
  logic                 ovf_evt;
  logic                 unf_evt;

  // Enters and exits net out before clamping, so a swap at a limit is not an error.
  always_comb begin
    n_enter = popcount(8'(enter_pulse));
    n_exit  = popcount(8'(exit_pulse));
    next_t  = $signed(TW'(count)) + $signed(TW'(n_enter)) - $signed(TW'(n_exit));
    ovf_evt = next_t > $signed(TW'(CAPACITY));
    unf_evt = next_t[TW-1];
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (ovf_evt)      count <= CNT_W'(CAPACITY);
      else if (unf_evt) count <= '0;
      else              count <= next_t[CNT_W-1:0];
      ovf_err <= (ovf_err & ~clear_err) | ovf_evt;
      unf_err <= (unf_err & ~clear_err) | unf_evt;
    end
  end

  assign full  = (count == CNT_W'(CAPACITY));
  assign empty = (count == '0);

endmodule

// File: tb/tb_parking_lot_counter.sv
// Bench for parking_lot_counter: vector table, directed corner sequences and a randomized run,
// all compared every cycle against a position-based behavioural model of a car crossing the beams.
module tb_parking_lot_counter;
  localparam int NG  = 2;
  localparam int CAP = 25;
  localparam int SS  = 2;
  localparam int CW  = $clog2(CAP + 1);

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic          clear_err;
  logic [NG-1:0] outer, inner;
  logic [NG-1:0] enter_pulse, exit_pulse;
  logic [CW-1:0] count;
  logic          full, empty, ovf_err, unf_err;

  parking_lot_counter #(.NUM_GATES(NG), .CAPACITY(CAP), .SYNC_STAGES(SS)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .outer       (outer),
    .inner       (inner),
    .clear_err   (clear_err),
    .enter_pulse (enter_pulse),
    .exit_pulse  (exit_pulse),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .ovf_err     (ovf_err),
    .unf_err     (unf_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_pass  = 0;
  int n_total = 0;

  // Model: each gate tracks a direction (+1 in, -1 out, 0 idle) and how far the car is along it.
  int              m_cnt;
  logic            m_ovf, m_unf;
  logic [NG-1:0]   m_en, m_ex;
  int              m_dir [NG];
  int              m_pos [NG];
  logic [2*NG-1:0] m_q [$];
  int              en_seen [NG];
  int              ex_seen [NG];

  typedef struct {
    int          gate;
    logic [11:0] seq;
    int          len;
    int          exp_en;
    int          exp_ex;
    int          exp_cnt;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int pos_of(input int dir, input logic [1:0] s);
    if (s == 2'b00) return 0;
    if (s == 2'b11) return 2;
    if (dir > 0) return (s == 2'b10) ? 1 : 3;
    return (s == 2'b01) ? 1 : 3;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_en  = '0;
    m_ex  = '0;
    for (int g = 0; g < NG; g++) begin
      m_dir[g] = 0;
      m_pos[g] = 0;
    end
    m_q.delete();
    for (int k = 0; k < SS; k++) m_q.push_back('0);
  endtask

  task automatic model_step();
    int              t;
    int              q;
    logic [2*NG-1:0] smp;
    logic [1:0]      s;
    t = m_cnt;
    for (int g = 0; g < NG; g++) t = t + int'(m_en[g]) - int'(m_ex[g]);
    if (clear_err) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (t > CAP) begin
      m_cnt = CAP;
      m_ovf = 1'b1;
    end else if (t < 0) begin
      m_cnt = 0;
      m_unf = 1'b1;
    end else m_cnt = t;
    smp = m_q.pop_front();
    m_q.push_back({outer, inner});
    for (int g = 0; g < NG; g++) begin
      s = {smp[NG+g], smp[g]};
      m_en[g] = 1'b0;
      m_ex[g] = 1'b0;
      if (m_dir[g] == 0) begin
        if (s == 2'b10) begin m_dir[g] = 1;  m_pos[g] = 1; end
        else if (s == 2'b01) begin m_dir[g] = -1; m_pos[g] = 1; end
      end else begin
        q = pos_of(m_dir[g], s);
        if (s == 2'b00 && m_pos[g] == 3) begin
          if (m_dir[g] > 0) m_en[g] = 1'b1;
          else              m_ex[g] = 1'b1;
          m_dir[g] = 0;
        end else if (q >= 1 && q - m_pos[g] >= -1 && q - m_pos[g] <= 1) m_pos[g] = q;
        else m_dir[g] = 0;
      end
    end
  endtask

  task automatic drive(input logic [NG-1:0] o, input logic [NG-1:0] i);
    logic [31:0] act, exp;
    outer = o;
    inner = i;
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
    act = 32'({enter_pulse, exit_pulse, count, full, empty, ovf_err, unf_err});
    exp = 32'({m_en, m_ex, CW'(m_cnt), (m_cnt == CAP), (m_cnt == 0), m_ovf, m_unf});
    check("cycle_vs_model", act, exp);
    for (int g = 0; g < NG; g++) begin
      en_seen[g] += int'(enter_pulse[g]);
      ex_seen[g] += int'(exit_pulse[g]);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) drive('0, '0);
  endtask

  // Lock-step crossing: gates in en walk inward while gates in ex walk outward.
  task automatic enter_exit(input logic [NG-1:0] en, input logic [NG-1:0] ex);
    drive(en, ex);
    drive(en | ex, en | ex);
    drive(ex, en);
    drive('0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  task automatic clear_seen();
    for (int g = 0; g < NG; g++) begin
      en_seen[g] = 0;
      ex_seen[g] = 0;
    end
  endtask

  logic [1:0]    s;
  logic [NG-1:0] ro, ri;
  vec_t          v;

  initial begin
    vecs[0] = '{gate: 0, seq: {2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00}, len: 5, exp_en: 1, exp_ex: 0, exp_cnt: 1};
    vecs[1] = '{gate: 0, seq: {2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00}, len: 5, exp_en: 1, exp_ex: 0, exp_cnt: 2};
    vecs[2] = '{gate: 0, seq: {2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00}, len: 4, exp_en: 0, exp_ex: 1, exp_cnt: 1};
    vecs[3] = '{gate: 0, seq: {2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, len: 2, exp_en: 0, exp_ex: 0, exp_cnt: 1};
    vecs[4] = '{gate: 0, seq: {2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00}, len: 4, exp_en: 0, exp_ex: 0, exp_cnt: 1};
    vecs[5] = '{gate: 0, seq: {2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00}, len: 6, exp_en: 0, exp_ex: 0, exp_cnt: 1};
    vecs[6] = '{gate: 1, seq: {2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00}, len: 6, exp_en: 1, exp_ex: 0, exp_cnt: 2};
    vecs[7] = '{gate: 1, seq: {2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00}, len: 4, exp_en: 0, exp_ex: 1, exp_cnt: 1};
    vecs[8] = '{gate: 0, seq: {2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, len: 2, exp_en: 0, exp_ex: 0, exp_cnt: 1};

    reset     = 1'b1;
    clear_err = 1'b0;
    outer     = '0;
    inner     = '0;
    model_reset();
    clear_seen();
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("reset_outputs", 32'({enter_pulse, exit_pulse, count, full, empty, ovf_err, unf_err}),
          32'({2'b00, 2'b00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
    reset = 1'b0;

    for (int n = 0; n < 9; n++) begin
      v = vecs[n];
      clear_seen();
      for (int k = 0; k < v.len; k++) begin
        s = v.seq[11-2*k -: 2];
        drive(NG'(s[1]) << v.gate, NG'(s[0]) << v.gate);
      end
      settle(5);
      check($sformatf("vec%0d_enters", n), 32'(en_seen[v.gate]), 32'(v.exp_en));
      check($sformatf("vec%0d_exits", n), 32'(ex_seen[v.gate]), 32'(v.exp_ex));
      check($sformatf("vec%0d_count", n), 32'(count), 32'(v.exp_cnt));
      check($sformatf("vec%0d_empty", n), 32'(empty), 32'(v.exp_cnt == 0));
    end

    // Fill to 24, then a double entry must clamp at capacity and raise overflow.
    repeat (11) enter_exit(2'b11, 2'b00);
    enter_exit(2'b01, 2'b00);
    settle(4);
    check("fill_count24", 32'(count), 32'd24);
    enter_exit(2'b11, 2'b00);
    settle(4);
    check("sat_count", 32'(count), 32'd25);
    check("sat_full", 32'(full), 32'd1);
    check("sat_ovf", 32'(ovf_err), 32'd1);
    clear_err = 1'b1;
    drive('0, '0);
    clear_err = 1'b0;
    check("clr_ovf", 32'(ovf_err), 32'd0);
    check("clr_full_kept", 32'(full), 32'd1);
    enter_exit(2'b01, 2'b10);
    settle(4);
    check("swap_at_full_count", 32'(count), 32'd25);
    check("swap_at_full_ovf", 32'(ovf_err), 32'd0);

    // Exit from empty, then a netted enter+exit at 5.
    do_reset();
    enter_exit(2'b00, 2'b01);
    settle(4);
    check("unf_count", 32'(count), 32'd0);
    check("unf_flag", 32'(unf_err), 32'd1);
    clear_err = 1'b1;
    drive('0, '0);
    clear_err = 1'b0;
    check("clr_unf", 32'(unf_err), 32'd0);
    repeat (2) enter_exit(2'b11, 2'b00);
    enter_exit(2'b01, 2'b00);
    settle(4);
    check("count5", 32'(count), 32'd5);
    enter_exit(2'b01, 2'b10);
    settle(4);
    check("swap_count5", 32'(count), 32'd5);
    check("swap_no_err", 32'({ovf_err, unf_err}), 32'd0);

    // Reset while gate 0 sits in the middle of an entry.
    do_reset();
    repeat (3) enter_exit(2'b01, 2'b00);
    settle(4);
    check("pre_reset_count3", 32'(count), 32'd3);
    drive(2'b01, 2'b00);
    repeat (3) drive(2'b01, 2'b01);
    clear_seen();
    do_reset();
    check("midseq_reset_count", 32'(count), 32'd0);
    check("midseq_reset_pulses", 32'({enter_pulse, exit_pulse}), 32'd0);
    drive(2'b00, 2'b01);
    drive(2'b00, 2'b00);
    settle(5);
    check("post_reset_no_pulse", 32'(en_seen[0] + ex_seen[0]), 32'd0);

    for (int it = 0; it < 700; it++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      clear_err = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 0) begin
        ro = NG'($urandom);
        ri = NG'($urandom) & ~ro;
        enter_exit(ro, ri);
      end else begin
        ro = NG'($urandom);
        ri = NG'($urandom);
        repeat ($urandom_range(1, 3)) drive(ro, ri);
      end
      clear_err = 1'b0;
    end
    settle(6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
